// File: rtl/dwt_pkg.sv
// Shared definitions for the DWT analysis stage: FSM state encoding of the
// FIR scheduler, band tags and the default datapath widths.
package dwt_pkg;

  // Default widths, shared with the FIR datapath modules.
  localparam int DWT_W_IN  = 7;   // signed sample width
  localparam int DWT_C_IN  = 5;   // signed coefficient width
  localparam int DWT_Y_OUT = 20;  // signed result width

  // Band tags on the output stream and on the config port.
  localparam logic BAND_LP = 1'b0;
  localparam logic BAND_HP = 1'b1;

  // Scheduler states: collect samples, issue LP then HP, capture the HP
  // result, then present LP and HP downstream.
  typedef enum logic [2:0] {
    S_LOAD,
    S_ISS_L,
    S_ISS_H,
    S_CAP,
    S_OUT_L,
    S_OUT_H
  } state_e;

endpackage

// File: rtl/dwt_coef_bank.sv
// 2x4 coefficient register file (lowpass / highpass banks). Writes are
// accepted only while the scheduler is in LOAD; a write at any other time is
// dropped and answered with a one-cycle err_o pulse on the following cycle.
module dwt_coef_bank
  import dwt_pkg::*;
#(
  parameter int C_IN = DWT_C_IN
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load_i,
  input  logic                   we_i,
  input  logic                   band_i,
  input  logic [1:0]             idx_i,
  input  logic signed [C_IN-1:0] data_i,
  output logic                   err_o,
  output logic signed [C_IN-1:0] lp_o [4],
  output logic signed [C_IN-1:0] hp_o [4]
);

  logic signed [C_IN-1:0] lp_q [4];
  logic signed [C_IN-1:0] hp_q [4];
  logic                   err_q;

  // Bank update and rejected-write flag.
  // NOTE: the banks are only eight small registers and must read as zero
  // straight out of reset, so they sit on the async reset like any flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 4; k++) begin
        lp_q[k] <= '0;
        hp_q[k] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      err_q <= we_i && !load_i;
      if (we_i && load_i) begin
        if (band_i == BAND_HP) hp_q[idx_i] <= data_i;
        else                   lp_q[idx_i] <= data_i;
      end
    end
  end

  assign err_o = err_q;
  assign lp_o  = lp_q;
  assign hp_o  = hp_q;

endmodule

// File: rtl/dwt_fir_sched.sv
// Scheduler for the shared 4-tap polyphase FIR datapath of the DWT analysis
// stage. Keeps a 4-deep sample window, issues the lowpass and then highpass
// coefficient set once per two new samples (first issue after four), and
// streams the tagged results out. dp_y is passed through bit-exact.
// Optional: define DWT_SCHED_STATS_EN to add the pair_cnt output, a 16-bit
// wrapping count of completed LP/HP pairs (cleared by rstn only).
module dwt_fir_sched
  import dwt_pkg::*;
#(
  parameter int W_IN  = DWT_W_IN,
  parameter int C_IN  = DWT_C_IN,
  parameter int Y_OUT = DWT_Y_OUT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [W_IN-1:0]  s_data,
  input  logic                    cfg_we,
  input  logic                    cfg_band,
  input  logic [1:0]              cfg_idx,
  input  logic signed [C_IN-1:0]  cfg_data,
  output logic                    cfg_err,
  output logic signed [W_IN-1:0]  dp_x_0,
  output logic signed [W_IN-1:0]  dp_x_1,
  output logic signed [W_IN-1:0]  dp_x_2,
  output logic signed [W_IN-1:0]  dp_x_3,
  output logic signed [C_IN-1:0]  dp_c_0,
  output logic signed [C_IN-1:0]  dp_c_1,
  output logic signed [C_IN-1:0]  dp_c_2,
  output logic signed [C_IN-1:0]  dp_c_3,
  input  logic signed [Y_OUT-1:0] dp_y,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [Y_OUT-1:0] m_data,
  output logic                    m_band,
  output logic                    busy
`ifdef DWT_SCHED_STATS_EN
  ,
  output logic [15:0]             pair_cnt
`endif
);

  state_e                  state_q;
  logic signed [W_IN-1:0]  win_q [4];   // win_q[0] is the newest sample
  logic [2:0]              fill_q;      // saturates at 4
  logic [2:0]              pend_q;      // samples since the last issue
  logic signed [Y_OUT-1:0] res_l_q;
  logic signed [Y_OUT-1:0] res_h_q;
  logic signed [Y_OUT-1:0] m_data_q;
  logic                    m_valid_q;
  logic                    m_band_q;

  logic                    load;
  logic                    s_hs;
  logic [2:0]              fill_d;
  logic [2:0]              pend_d;
  logic signed [C_IN-1:0]  lp_c [4];
  logic signed [C_IN-1:0]  hp_c [4];
  logic signed [C_IN-1:0]  coef_sel [4];

  assign load    = (state_q == S_LOAD);
  // A sample presented together with flush is never taken.
  assign s_ready = load && !flush;
  assign s_hs    = s_valid && s_ready;
  assign fill_d  = (fill_q >= 3'd4) ? 3'd4 : fill_q + 3'd1;
  assign pend_d  = pend_q + 3'd1;

  dwt_coef_bank #(.C_IN(C_IN)) u_coef_bank (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load),
    .we_i   (cfg_we),
    .band_i (cfg_band),
    .idx_i  (cfg_idx),
    .data_i (cfg_data),
    .err_o  (cfg_err),
    .lp_o   (lp_c),
    .hp_o   (hp_c)
  );

  // Scheduler FSM with window, result capture and registered stream outputs.
  // NOTE: every register here uses <= so all of them sample the values from
  // before the edge; the window shift relies on that ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_LOAD;
      for (int k = 0; k < 4; k++) win_q[k] <= '0;
      fill_q    <= '0;
      pend_q    <= '0;
      res_l_q   <= '0;
      res_h_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_band_q  <= BAND_LP;
    end else if (flush) begin
      state_q   <= S_LOAD;
      for (int k = 0; k < 4; k++) win_q[k] <= '0;
      fill_q    <= '0;
      pend_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (s_hs) begin
            win_q[0] <= s_data;
            for (int k = 1; k < 4; k++) win_q[k] <= win_q[k-1];
            fill_q <= fill_d;
            if (fill_d >= 3'd4 && pend_d >= 3'd2) begin
              pend_q  <= '0;
              state_q <= S_ISS_L;
            end else begin
              pend_q  <= pend_d;
            end
          end
        end
        S_ISS_L: state_q <= S_ISS_H;
        S_ISS_H: begin
          res_l_q <= dp_y;
          state_q <= S_CAP;
        end
        S_CAP: begin
          res_h_q   <= dp_y;
          m_valid_q <= 1'b1;
          m_data_q  <= res_l_q;
          m_band_q  <= BAND_LP;
          state_q   <= S_OUT_L;
        end
        S_OUT_L: begin
          if (m_ready) begin
            m_data_q <= res_h_q;
            m_band_q <= BAND_HP;
            state_q  <= S_OUT_H;
          end
        end
        S_OUT_H: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

`ifdef DWT_SCHED_STATS_EN
  logic [15:0] pair_cnt_q;

  // Completed-pair counter; survives flush, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                               pair_cnt_q <= '0;
    else if (!flush && state_q == S_OUT_H && m_ready)        pair_cnt_q <= pair_cnt_q + 16'd1;
  end

  assign pair_cnt = pair_cnt_q;
`endif

  // Coefficient mux: a bank is only presented while it is being issued.
  // NOTE: the zero default ahead of the case keeps this purely combinational
  // for the states that do not drive a bank.
  always_comb begin
    for (int k = 0; k < 4; k++) coef_sel[k] = '0;
    if (state_q == S_ISS_L) coef_sel = lp_c;
    else if (state_q == S_ISS_H) coef_sel = hp_c;
  end

  assign dp_x_0  = win_q[0];
  assign dp_x_1  = win_q[1];
  assign dp_x_2  = win_q[2];
  assign dp_x_3  = win_q[3];
  assign dp_c_0  = coef_sel[0];
  assign dp_c_1  = coef_sel[1];
  assign dp_c_2  = coef_sel[2];
  assign dp_c_3  = coef_sel[3];
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_band  = m_band_q;
  assign busy    = !load;

endmodule

// File: tb/tb_dwt_fir_sched.sv
// Directed bench for dwt_fir_sched. The FIR datapath is modelled as a
// registered sum of dp_x_k*dp_c_k; expected results are hand-computed.
module tb_dwt_fir_sched;

  logic               clk;
  logic               rstn;
  logic               flush;
  logic               s_valid;
  logic               s_ready;
  logic signed [6:0]  s_data;
  logic               cfg_we;
  logic               cfg_band;
  logic [1:0]         cfg_idx;
  logic signed [4:0]  cfg_data;
  logic               cfg_err;
  logic signed [6:0]  dp_x_0, dp_x_1, dp_x_2, dp_x_3;
  logic signed [4:0]  dp_c_0, dp_c_1, dp_c_2, dp_c_3;
  logic signed [19:0] dp_y;
  logic               m_valid;
  logic               m_ready;
  logic signed [19:0] m_data;
  logic               m_band;
  logic               busy;
`ifdef DWT_SCHED_STATS_EN
  logic [15:0]        pair_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dwt_fir_sched dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .cfg_we   (cfg_we),
    .cfg_band (cfg_band),
    .cfg_idx  (cfg_idx),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .dp_x_0   (dp_x_0),
    .dp_x_1   (dp_x_1),
    .dp_x_2   (dp_x_2),
    .dp_x_3   (dp_x_3),
    .dp_c_0   (dp_c_0),
    .dp_c_1   (dp_c_1),
    .dp_c_2   (dp_c_2),
    .dp_c_3   (dp_c_3),
    .dp_y     (dp_y),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_band   (m_band),
    .busy     (busy)
`ifdef DWT_SCHED_STATS_EN
    ,
    .pair_cnt (pair_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: registered dot product, one cycle of latency.
  always_ff @(posedge clk) begin
    dp_y <= dp_x_0 * dp_c_0 + dp_x_1 * dp_c_1 + dp_x_2 * dp_c_2 + dp_x_3 * dp_c_3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench did not complete");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic band, input logic [1:0] idx, input int val);
    cfg_we   = 1'b1;
    cfg_band = band;
    cfg_idx  = idx;
    cfg_data = 5'(val);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic send(input int val);
    s_valid = 1'b1;
    s_data  = 7'(val);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Called in the cycle LP should appear (m_ready high): LP, then HP, then idle.
  task automatic expect_pair(input string tag, input int lp, input int hp);
    check({tag, "_lp_valid"}, int'(m_valid), 1);
    check({tag, "_lp_band"},  int'(m_band),  0);
    check({tag, "_lp_data"},  int'(m_data),  lp);
    step(1);
    check({tag, "_hp_valid"}, int'(m_valid), 1);
    check({tag, "_hp_band"},  int'(m_band),  1);
    check({tag, "_hp_data"},  int'(m_data),  hp);
    step(1);
    check({tag, "_idle_valid"}, int'(m_valid), 0);
    check({tag, "_idle_busy"},  int'(busy),    0);
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_we = 1'b0; cfg_band = 1'b0; cfg_idx = '0; cfg_data = '0;
    m_ready = 1'b1;
    step(2);

    // Reset values
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data",  int'(m_data),  0);
    check("rst_m_band",  int'(m_band),  0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_dp_x_0",  int'(dp_x_0),  0);
    check("rst_dp_c_0",  int'(dp_c_0),  0);
    rstn = 1'b1;
    step(1);

    // Banks: LP = {1,1,1,1}, HP = {1,-1,1,-1}
    for (int k = 0; k < 4; k++) cfg_write(1'b0, 2'(k), 1);
    for (int k = 0; k < 4; k++) cfg_write(1'b1, 2'(k), (k % 2 == 0) ? 1 : -1);
    check("cfg_load_no_err", int'(cfg_err), 0);

    // First issue after the 4th sample: window 4,3,2,1 -> LP 10, HP 2
    send(1); send(2); send(3);
    check("no_issue_at_3", int'(busy), 0);
    send(4);
    check("iss_l_busy",    int'(busy),    1);
    check("iss_l_s_ready", int'(s_ready), 0);
    check("iss_l_x0",      int'(dp_x_0),  4);
    check("iss_l_x3",      int'(dp_x_3),  1);
    check("iss_l_c1",      int'(dp_c_1),  1);
    step(1);
    check("iss_h_c1",      int'(dp_c_1),  -1);
    check("iss_h_c3",      int'(dp_c_3),  -1);
    step(1);
    check("cap_c0",        int'(dp_c_0),  0);
    check("cap_m_valid",   int'(m_valid), 0);
    step(1);
    expect_pair("pair1", 10, 2);

    // Decimation: nothing after sample 5 alone; window 6,5,4,3 -> 18, 2
    send(5);
    step(1);
    check("no_issue_at_5", int'(busy), 0);
    send(6);
    step(3);
    expect_pair("pair2", 18, 2);

    // Backpressure in OUT_L: window 8,7,6,5 -> LP 26 held, then HP 2
    m_ready = 1'b0;
    send(7); send(8);
    step(3);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",   int'(m_valid), 1);
      check("bp_data",    int'(m_data),  26);
      check("bp_band",    int'(m_band),  0);
      check("bp_s_ready", int'(s_ready), 0);
      if (i < 2) step(1);
    end
    m_ready = 1'b1;
    step(1);
    check("bp_hp_band", int'(m_band), 1);
    check("bp_hp_data", int'(m_data), 2);
    step(1);
    check("bp_done", int'(m_valid), 0);

    // Write during ISS_H (HP tap1 := 5) is rejected; window 10,9,8,7
    send(9); send(10);
    step(1);
    cfg_we = 1'b1; cfg_band = 1'b1; cfg_idx = 2'd1; cfg_data = 5'sd5;
    step(1);
    cfg_we = 1'b0;
    check("cfg_err_pulse", int'(cfg_err), 1);
    step(1);
    check("cfg_err_clear", int'(cfg_err), 0);
    expect_pair("pair3", 34, 2);

    // Write with the issuing handshake: LP tap0 := 3; window 12,11,10,9
    // LP = 36+11+10+9 = 66; HP still 12-11+10-9 = 2
    send(11);
    s_valid = 1'b1; s_data = 7'sd12;
    cfg_we = 1'b1; cfg_band = 1'b0; cfg_idx = 2'd0; cfg_data = 5'sd3;
    step(1);
    s_valid = 1'b0; cfg_we = 1'b0;
    check("cfg_issue_no_err", int'(cfg_err), 0);
    step(3);
    expect_pair("pair4", 66, 2);

    // Flush in OUT_L, with a sample offered that must be dropped
    m_ready = 1'b0;
    send(13); send(14);
    step(3);
    check("pre_flush_data", int'(m_data), 78);
    flush = 1'b1; s_valid = 1'b1; s_data = 7'sd99;
    step(1);
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    check("flush_m_valid", int'(m_valid), 0);
    check("flush_busy",    int'(busy),    0);
    send(7); send(8); send(9);
    check("flush_refill", int'(busy), 0);
    send(10);
    step(3);
    expect_pair("pair5", 54, 2);

    // Reset while in CAP
    send(11); send(12);
    step(2);
    rstn = 1'b0;
    #1;
    check("arst_busy",    int'(busy),    0);
    check("arst_s_ready", int'(s_ready), 1);
    check("arst_m_valid", int'(m_valid), 0);
    check("arst_m_data",  int'(m_data),  0);
    check("arst_m_band",  int'(m_band),  0);
    check("arst_dp_x_0",  int'(dp_x_0),  0);
    step(1);
    rstn = 1'b1;
    step(1);
    send(1); send(2); send(3); send(4);
    check("arst_bank_c0", int'(dp_c_0), 0);
    step(3);
    expect_pair("pair6", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
